// File: rtl/huff4x4_decoder.sv
// Serial Huffman decoder for 4x4 blocks: code accumulation, DC/AC control and lookup tables.
// Optional DC prediction is enabled by defining DC_PRED_EN.
module huff4x4_decoder #(
  parameter int unsigned MAX_LEN = 9,
  parameter int unsigned COEFF_W = 10
) (
  input  logic               phi1,
  input  logic               reset_b_s1,
  input  logic               bit_en_s1,
  input  logic               bitstream_s1,
  input  logic               rw1_en_s1,
  input  logic [4:0]         t1_addr_s1,
  input  logic [MAX_LEN-1:0] maxcode_v1,
  input  logic [5:0]         base_v1,
  input  logic               rw2_en_s1,
  input  logic [5:0]         t2_addr_s1,
  input  logic [3:0]         coeff_size_v1,
  input  logic [1:0]         run_length_v1,
  output logic [COEFF_W-1:0] coefficient_s2,
  output logic [3:0]         position_s2,
  output logic               valid_s2,
  output logic               new_block_s2
);

  localparam int unsigned T1_DEPTH = 32;
  localparam int unsigned T2_AW    = 6;
  localparam int unsigned T2_DEPTH = 64;
  localparam int unsigned LEN_W    = 4;
  localparam int unsigned POS_W    = 4;
  localparam int unsigned SIZE_W   = 4;
  localparam int unsigned RUN_W    = 2;

  typedef enum logic [1:0] {DC_CODE, DC_MAG, AC_CODE, AC_MAG} state_t;

  logic [MAX_LEN-1:0] maxcode_mem [T1_DEPTH];
  logic [T2_AW-1:0]   base_mem    [T1_DEPTH];
  logic [SIZE_W-1:0]  size_mem    [T2_DEPTH];
  logic [RUN_W-1:0]   run_mem     [T2_DEPTH];

  state_t             state_q, state_d;
  logic [MAX_LEN-2:0] code_q, code_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [SIZE_W-1:0]  size_q, size_d;
  logic [SIZE_W-1:0]  cnt_q, cnt_d;
  logic [COEFF_W-2:0] raw_q, raw_d;
  logic [COEFF_W-1:0] coef_d;
  logic [POS_W-1:0]   posout_d;
  logic               valid_d, nb_d;

  logic               is_dc;
  logic [MAX_LEN-1:0] code_new;
  logic [4:0]         t1_idx;
  logic [MAX_LEN-1:0] max_sel;
  logic [T2_AW-1:0]   base_sel, t2_idx;
  logic               match;
  logic [SIZE_W-1:0]  t2_size;
  logic [RUN_W-1:0]   t2_run;
  logic [POS_W:0]     pos_ext;
  logic [COEFF_W-1:0] raw_new, mag_off, mag_val, dc_in, dc_out;
  logic               mag_msb;

  // Table storage is never reset; contents survive reset_b_s1.
  always_ff @(posedge phi1) begin
    if (rw1_en_s1) begin
      maxcode_mem[t1_addr_s1] <= maxcode_v1;
      base_mem[t1_addr_s1]    <= base_v1;
    end
    if (rw2_en_s1) begin
      size_mem[t2_addr_s1] <= coeff_size_v1;
      run_mem[t2_addr_s1]  <= run_length_v1;
    end
  end

  // Lookup path: the code including the current bit is matched against its length's bound.
  assign is_dc    = (state_q == DC_CODE);
  assign code_new = {code_q, bitstream_s1};
  assign t1_idx   = {is_dc, len_q};
  assign max_sel  = maxcode_mem[t1_idx];
  assign base_sel = base_mem[t1_idx];
  assign match    = (code_new < max_sel);
  assign t2_idx   = base_sel + code_new[T2_AW-1:0];
  assign t2_size  = size_mem[t2_idx];
  assign t2_run   = run_mem[t2_idx];
  assign pos_ext  = (POS_W+1)'(pos_q) + (POS_W+1)'(t2_run) + (POS_W+1)'(1);

  // Magnitude: MSB clear means a negative value offset by 2^size - 1.
  assign raw_new = {raw_q, bitstream_s1};
  assign mag_msb = raw_new[size_q - SIZE_W'(1)];
  assign mag_off = COEFF_W'((32'd1 << size_q) - 32'd1);
  assign mag_val = mag_msb ? raw_new : (raw_new - mag_off);
  assign dc_in   = is_dc ? '0 : mag_val;

`ifdef DC_PRED_EN
  logic [COEFF_W-1:0] pred_q, pred_d;
  assign dc_out = pred_q + dc_in;
`else
  assign dc_out = dc_in;
`endif

  always_ff @(posedge phi1 or negedge reset_b_s1) begin
    if (!reset_b_s1) begin
      state_q        <= DC_CODE;
      code_q         <= '0;
      len_q          <= '0;
      pos_q          <= '0;
      size_q         <= '0;
      cnt_q          <= '0;
      raw_q          <= '0;
      coefficient_s2 <= '0;
      position_s2    <= '0;
      valid_s2       <= 1'b0;
      new_block_s2   <= 1'b0;
`ifdef DC_PRED_EN
      pred_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      len_q          <= len_d;
      pos_q          <= pos_d;
      size_q         <= size_d;
      cnt_q          <= cnt_d;
      raw_q          <= raw_d;
      coefficient_s2 <= coef_d;
      position_s2    <= posout_d;
      valid_s2       <= valid_d;
      new_block_s2   <= nb_d;
`ifdef DC_PRED_EN
      pred_q         <= pred_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    len_d    = len_q;
    pos_d    = pos_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    raw_d    = raw_q;
    coef_d   = coefficient_s2;
    posout_d = position_s2;
    valid_d  = 1'b0;
    nb_d     = 1'b0;
`ifdef DC_PRED_EN
    pred_d   = pred_q;
`endif
    if (bit_en_s1) begin
      case (state_q)
        DC_CODE, AC_CODE: begin
          code_d = code_new[MAX_LEN-2:0];
          len_d  = len_q + LEN_W'(1);
          if (match) begin
            code_d = '0;
            len_d  = '0;
            if (is_dc) begin
              pos_d = '0;
              if (t2_size == '0) begin
                valid_d  = 1'b1;
                coef_d   = dc_out;
                posout_d = '0;
                state_d  = AC_CODE;
`ifdef DC_PRED_EN
                pred_d   = dc_out;
`endif
              end else begin
                size_d  = t2_size;
                cnt_d   = t2_size;
                raw_d   = '0;
                state_d = DC_MAG;
              end
            end else if ((t2_size == '0) && (t2_run == '0)) begin
              nb_d    = 1'b1;
              pos_d   = '0;
              state_d = DC_CODE;
            end else if (pos_ext[POS_W]) begin
              // Run would place the coefficient past the last position.
              nb_d    = 1'b1;
              pos_d   = '0;
              state_d = DC_CODE;
            end else if (t2_size == '0) begin
              pos_d = pos_ext[POS_W-1:0];
            end else begin
              pos_d   = pos_ext[POS_W-1:0];
              size_d  = t2_size;
              cnt_d   = t2_size;
              raw_d   = '0;
              state_d = AC_MAG;
            end
          end else if (len_q == LEN_W'(MAX_LEN - 1)) begin
            code_d  = '0;
            len_d   = '0;
            nb_d    = 1'b1;
            pos_d   = '0;
            state_d = DC_CODE;
          end
        end
        DC_MAG, AC_MAG: begin
          raw_d = raw_new[COEFF_W-2:0];
          cnt_d = cnt_q - SIZE_W'(1);
          if (cnt_q == SIZE_W'(1)) begin
            valid_d = 1'b1;
            if (state_q == DC_MAG) begin
              coef_d   = dc_out;
              posout_d = '0;
              state_d  = AC_CODE;
`ifdef DC_PRED_EN
              pred_d   = dc_out;
`endif
            end else begin
              coef_d   = mag_val;
              posout_d = pos_q;
              if (pos_q == POS_W'(15)) begin
                nb_d    = 1'b1;
                pos_d   = '0;
                state_d = DC_CODE;
              end else begin
                state_d = AC_CODE;
              end
            end
          end
        end
        default: state_d = DC_CODE;
      endcase
    end
  end

endmodule

// File: tb/tb_huff4x4_decoder.sv
// Self-checking bench for huff4x4_decoder: directed and random bitstreams against a stream-parsing model.
module tb_huff4x4_decoder;

  logic       phi1 = 1'b0;
  logic       reset_b_s1, bit_en_s1, bitstream_s1;
  logic       rw1_en_s1, rw2_en_s1;
  logic [4:0] t1_addr_s1;
  logic [8:0] maxcode_v1;
  logic [5:0] base_v1, t2_addr_s1;
  logic [3:0] coeff_size_v1;
  logic [1:0] run_length_v1;
  logic [9:0] coefficient_s2;
  logic [3:0] position_s2;
  logic       valid_s2, new_block_s2;

  huff4x4_decoder dut (
    .phi1(phi1), .reset_b_s1(reset_b_s1), .bit_en_s1(bit_en_s1), .bitstream_s1(bitstream_s1),
    .rw1_en_s1(rw1_en_s1), .t1_addr_s1(t1_addr_s1), .maxcode_v1(maxcode_v1), .base_v1(base_v1),
    .rw2_en_s1(rw2_en_s1), .t2_addr_s1(t2_addr_s1), .coeff_size_v1(coeff_size_v1),
    .run_length_v1(run_length_v1), .coefficient_s2(coefficient_s2), .position_s2(position_s2),
    .valid_s2(valid_s2), .new_block_s2(new_block_s2)
  );

  always #5 phi1 = ~phi1;

  int tests = 0;
  int fails = 0;
  int m_max [2][10];
  int m_base[2][10];
  int m_size[64];
  int m_run [64];
  bit bits[$];
  bit ev_v[1024];
  bit ev_nb[1024];
  int ev_c[1024];
  int ev_p[1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr1(input int dc, input int len, input int mx, input int bs);
    @(negedge phi1);
    rw1_en_s1  = 1'b1;
    t1_addr_s1 = 5'((dc << 4) | (len - 1));
    maxcode_v1 = 9'(mx);
    base_v1    = 6'(bs);
    m_max[dc][len]  = mx;
    m_base[dc][len] = bs;
    @(posedge phi1); #1;
    rw1_en_s1 = 1'b0;
  endtask

  task automatic wr2(input int a, input int sz, input int rn);
    @(negedge phi1);
    rw2_en_s1     = 1'b1;
    t2_addr_s1    = 6'(a);
    coeff_size_v1 = 4'(sz);
    run_length_v1 = 2'(rn);
    m_size[a] = sz;
    m_run[a]  = rn;
    @(posedge phi1); #1;
    rw2_en_s1 = 1'b0;
  endtask

  task automatic clear_t1();
    for (int dc = 0; dc < 2; dc++)
      for (int len = 1; len <= 9; len++) wr1(dc, len, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge phi1); #2;
    reset_b_s1 = 1'b0;
    bit_en_s1  = 1'b0;
    @(negedge phi1);
    reset_b_s1 = 1'b1;
  endtask

  task automatic add(input string s);
    for (int i = 0; i < s.len(); i++) bits.push_back(s[i] == 8'h31);
  endtask

  // Walk the whole bitstream symbol by symbol; record the expected outputs keyed by the index of the bit that completes each event.
  task automatic parse();
    int n, i, code, len, a, sz, rn, np, raw, v, pos, pr;
    bit dc, hit, ovf;
    n = bits.size(); i = 0; dc = 1; pos = 0; pr = 0;
    for (int k = 0; k < 1024; k++) begin ev_v[k] = 0; ev_nb[k] = 0; ev_c[k] = 0; ev_p[k] = 0; end
    while (i < n) begin
      code = 0; len = 0; hit = 0; ovf = 0;
      while (!hit && !ovf && i < n) begin
        code = code * 2 + int'(bits[i]); i++; len++;
        if (code < m_max[dc][len]) hit = 1;
        else if (len == 9) ovf = 1;
      end
      if (ovf) begin ev_nb[i-1] = 1; dc = 1; pos = 0; continue; end
      if (!hit) break;
      a = (m_base[dc][len] + code) % 64; sz = m_size[a]; rn = m_run[a];
      np = dc ? 0 : pos + rn + 1;
      if (!dc && sz == 0 && rn == 0) begin ev_nb[i-1] = 1; dc = 1; pos = 0; continue; end
      if (!dc && np > 15) begin ev_nb[i-1] = 1; dc = 1; pos = 0; continue; end
      if (!dc && sz == 0) begin pos = np; continue; end
      if (i + sz > n) break;
      raw = 0;
      for (int j = 0; j < sz; j++) begin raw = raw * 2 + int'(bits[i]); i++; end
      v = (sz == 0) ? 0 : ((raw >= (1 << (sz - 1))) ? raw : raw - ((1 << sz) - 1));
      if (dc) begin
`ifdef DC_PRED_EN
        pr = (pr + v) & 1023;
        v  = pr;
`endif
        dc = 0;
      end else if (np == 15) begin
        ev_nb[i-1] = 1; dc = 1; np = 0;
      end
      ev_v[i-1] = 1; ev_c[i-1] = v & 1023; ev_p[i-1] = (dc || np == 0) ? ((ev_nb[i-1]) ? 15 : 0) : np;
      pos = np;
    end
  endtask

  task automatic run_bits(input int gap_pct);
    for (int k = 0; k < bits.size(); k++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        @(negedge phi1); bit_en_s1 = 1'b0;
        @(posedge phi1); #1;
        chk("idle_valid", 32'(valid_s2), 0);
        chk("idle_new_block", 32'(new_block_s2), 0);
      end
      @(negedge phi1); bit_en_s1 = 1'b1; bitstream_s1 = bits[k];
      @(posedge phi1); #1;
      chk($sformatf("valid[%0d]", k), 32'(valid_s2), 32'(ev_v[k]));
      chk($sformatf("new_block[%0d]", k), 32'(new_block_s2), 32'(ev_nb[k]));
      if (ev_v[k]) begin
        chk($sformatf("coefficient[%0d]", k), 32'(coefficient_s2), 32'(ev_c[k]));
        chk($sformatf("position[%0d]", k), 32'(position_s2), 32'(ev_p[k]));
      end
    end
    @(negedge phi1); bit_en_s1 = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_coefficient"}, 32'(coefficient_s2), 0);
    chk({tag, "_position"}, 32'(position_s2), 0);
    chk({tag, "_valid"}, 32'(valid_s2), 0);
    chk({tag, "_new_block"}, 32'(new_block_s2), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b_s1 = 1'b0; bit_en_s1 = 1'b0; bitstream_s1 = 1'b0;
    rw1_en_s1 = 1'b0; rw2_en_s1 = 1'b0; t1_addr_s1 = '0; maxcode_v1 = '0; base_v1 = '0;
    t2_addr_s1 = '0; coeff_size_v1 = '0; run_length_v1 = '0;
    repeat (2) @(negedge phi1);
    chk_outputs_zero("reset");
    reset_b_s1 = 1'b1;

    // AC runs up to the final position, then a negative DC.
    do_reset(); clear_t1();
    wr1(1, 2, 1, 0); wr2(0, 3, 0);
    wr1(0, 1, 1, 1); wr2(1, 1, 2);
    bits.delete(); add("00101"); add("01"); add("00"); add("01"); add("01"); add("01"); add("00010");
    parse(); run_bits(0);

    // EOB and DC differences 5, -2, -5 across blocks.
    do_reset(); clear_t1();
    wr1(1, 2, 1, 0); wr1(1, 3, 3, 0); wr1(0, 2, 2, 0);
    wr2(0, 3, 0); wr2(1, 0, 0); wr2(2, 2, 0);
    bits.delete(); add("00101"); add("01"); add("01001"); add("01"); add("00010");
    parse(); run_bits(0);

    // Reset in the middle of an AC magnitude; tables must survive it.
    do_reset();
    bits.delete(); add("00101"); add("00"); add("1");
    parse(); run_bits(0);
    @(negedge phi1); #2;
    reset_b_s1 = 1'b0; #1;
    chk_outputs_zero("mid_mag_reset");
    @(negedge phi1); reset_b_s1 = 1'b1;
    bits.delete(); add("00101");
    parse(); run_bits(0);

    // Run pushing past position 15, then a 9-bit unmatched code.
    do_reset(); clear_t1();
    wr1(1, 2, 1, 0); wr2(0, 3, 0);
    wr1(0, 1, 1, 2); wr2(2, 0, 3);
    bits.delete(); add("00101"); add("0000"); add("111111111"); add("00101");
    parse(); run_bits(20);

    // Random tables and bitstreams.
    repeat (6) begin
      do_reset();
      for (int dc = 0; dc < 2; dc++)
        for (int len = 1; len <= 9; len++)
          wr1(dc, len, int'($urandom_range(0, (len == 9) ? 511 : (1 << len))), int'($urandom_range(0, 63)));
      for (int a = 0; a < 64; a++) wr2(a, int'($urandom_range(0, 10)), int'($urandom_range(0, 3)));
      bits.delete();
      for (int k = 0; k < 400; k++) bits.push_back(1'($urandom_range(0, 1)));
      parse(); run_bits(15);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
